// File: rtl/game_pkg.sv
// Shared screen definitions for the Mario VGA design.
// The screen mux, the renderer and the screen sequencer all use screen_t.
// It selects which drawer (start screen, level, win screen, lose screen)
// is currently visible.
package game_pkg;

    typedef enum logic [1:0] {
        START = 2'd0,
        PLAY  = 2'd1,
        WIN   = 2'd2,
        LOSE  = 2'd3
    } screen_t;

    localparam int SCREEN_COUNT = 4;

endpackage

// File: rtl/button_debouncer.sv
// Jump-button conditioner: a 2-flop synchronizer, a stability counter and a
// rising-edge detector.
//   clk    : pixel clock
//   rst    : asynchronous active-high reset
//   button : raw asynchronous push button (active high)
//   level  : debounced button level
//   press  : registered one-cycle pulse on each debounced rising edge
// A change on the synchronized input is accepted only after it has been
// stable for DEBOUNCE_CYCLES consecutive samples.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic level,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta_reg;
    logic             sync_reg;
    logic             db_reg;
    logic             db_prev_reg;
    logic             press_reg;
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_reg    <= 1'b0;
            sync_reg    <= 1'b0;
            db_reg      <= 1'b0;
            db_prev_reg <= 1'b0;
            press_reg   <= 1'b0;
            cnt_reg     <= '0;
        end else begin
            meta_reg <= button;
            sync_reg <= meta_reg;

            // Any sample that agrees with the accepted level restarts the count.
            // A glitch therefore has to last the full window to get through.
            if (sync_reg != db_reg) begin
                if (cnt_reg == CNT_LAST) begin
                    db_reg  <= sync_reg;
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end else begin
                cnt_reg <= '0;
            end

            db_prev_reg <= db_reg;
            press_reg   <= db_reg & ~db_prev_reg;
        end
    end

    assign level = db_reg;
    assign press = press_reg;

endmodule

// File: rtl/game_screen_sequencer.sv
// Top-level screen controller: START -> PLAY -> WIN/LOSE -> START.
//   vga_clock   : pixel clock (only clock)
//   reset       : asynchronous active-high reset
//   jump_button : raw jump button, debounced internally
//   frame_start : one-cycle pulse per video frame
//   win, lose   : level drawer result flags (honoured only in PLAY)
//   screen_sel  : current screen as screen_t
//   level_reset : holds the level drawer in reset outside PLAY
//   hold_active : end screen is still inside its minimum display time
//   leds        : [3:0] one-hot screen, [4] debounced button, [9:5] zero
module game_screen_sequencer
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int END_HOLD_FRAMES = 180
) (
    input  logic       vga_clock,
    input  logic       reset,
    input  logic       jump_button,
    input  logic       frame_start,
    input  logic       win,
    input  logic       lose,
    output logic [1:0] screen_sel,
    output logic       level_reset,
    output logic       hold_active,
    output logic [9:0] leds
);

    localparam int HOLD_W = $clog2(END_HOLD_FRAMES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(END_HOLD_FRAMES);

    screen_t                 state_reg, state_next;
    logic [HOLD_W-1:0]       hold_cnt_reg, hold_cnt_next;
    logic                    level_reset_reg;
    logic                    hold_active_reg;
    logic [SCREEN_COUNT-1:0] leds_state_reg;
    logic                    db_level;
    logic                    press;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk    (vga_clock),
        .rst    (reset),
        .button (jump_button),
        .level  (db_level),
        .press  (press)
    );

    always_comb begin
        state_next    = state_reg;
        hold_cnt_next = hold_cnt_reg;

        unique case (state_reg)
            START: if (press) state_next = PLAY;
            PLAY: begin
                if (win)       state_next = WIN;
                else if (lose) state_next = LOSE;
            end
            // The registered hold flag is used here, so a press that lands
            // on the final decrement is still discarded.
            WIN, LOSE: if (press && !hold_active_reg) state_next = START;
            default:   state_next = START;
        endcase

        // The load on entry wins over a coincident frame_start, so the
        // entry frame never counts toward the hold time.
        if (state_reg == PLAY && (state_next == WIN || state_next == LOSE)) begin
            hold_cnt_next = HOLD_LOAD;
        end else if (state_next == START || state_next == PLAY) begin
            hold_cnt_next = '0;
        end else if (frame_start && hold_cnt_reg != '0) begin
            hold_cnt_next = hold_cnt_reg - HOLD_W'(1);
        end
    end

    always_ff @(posedge vga_clock or posedge reset) begin
        if (reset) begin
            state_reg       <= START;
            hold_cnt_reg    <= '0;
            level_reset_reg <= 1'b1;
            hold_active_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            hold_cnt_reg    <= hold_cnt_next;
            level_reset_reg <= (state_next != PLAY);
            hold_active_reg <= (hold_cnt_next != '0);
        end
    end

    // One-hot screen indicator, decoded from the next state so it moves
    // together with the state register.
    generate
        for (genvar gi = 0; gi < SCREEN_COUNT; gi++) begin : g_led_state
            always_ff @(posedge vga_clock or posedge reset) begin
                if (reset) begin
                    leds_state_reg[gi] <= (gi == 0);
                end else begin
                    leds_state_reg[gi] <= (state_next == screen_t'(gi));
                end
            end
        end
    endgenerate

    assign screen_sel  = state_reg;
    assign level_reset = level_reset_reg;
    assign hold_active = hold_active_reg;
    assign leds        = {5'b00000, db_level, leds_state_reg};

endmodule

// File: doc/game_screen_sequencer.md
# game_screen_sequencer

Top-level screen controller for the Mario VGA design. It debounces the jump button and runs the START → PLAY → WIN/LOSE → START game flow. Its `screen_sel` output selects which drawer (start screen, level, win screen, lose screen) feeds the tile/sprite renderer. It also holds the level drawer in reset outside of play and enforces a minimum display time on end screens.

## Interface
- `DEBOUNCE_CYCLES`, default 250000: consecutive stable synchronized samples required to accept a button change (10 ms at 25 MHz); must be ≥ 2.
- `END_HOLD_FRAMES`, default 180: frames that WIN/LOSE is shown before a jump press is accepted (3 s at 60 Hz); must be ≥ 1.
- `vga_clock` input, 1 bit: pixel clock; the only clock in the block.
- `reset` input, 1 bit: asynchronous, active-high.
- `jump_button` input, 1 bit: raw, asynchronous, active-high push button.
- `frame_start` input, 1 bit: one-cycle pulse per frame from the VGA timing generator.
- `win` input, 1 bit: level drawer win flag; level.
- `lose` input, 1 bit: level drawer lose flag; level.
- `screen_sel` output, 2 bits: current screen, encoded as `screen_t`.
- `level_reset` output, 1 bit: high whenever the state is not PLAY.
- `hold_active` output, 1 bit: high while the end-screen hold counter is nonzero.
- `leds` output, 10 bits: [3:0] one-hot state (bit = `screen_t` value), [4] debounced button, [9:5] = 0.

## Operation
- Synchronizer: 2-flop synchronizer on `jump_button` produces `sync_q`.
- Debouncer:
  - Counter increments each cycle that `sync_q` ≠ `db_q`, and clears when they are equal.
  - When the counter equals `DEBOUNCE_CYCLES`-1 and `sync_q` still differs, `db_q` takes `sync_q` and the counter clears.
  - Counter width is `$clog2(DEBOUNCE_CYCLES)`.
- `press`: registered one-cycle pulse on a `db_q` rising edge. A held button produces exactly one `press`; a release produces none.
- State machine (`screen_t`: START=0, PLAY=1, WIN=2, LOSE=3):
  - START: `press` → PLAY.
  - PLAY:
    - `win` → WIN.
    - `lose` → LOSE.
    - `win` and `lose` in the same cycle → WIN (win has priority).
    - `press` is ignored.
  - WIN/LOSE: `press` while `hold_active`=0 → START. `press` while `hold_active`=1 is discarded, not queued.
  - `win`/`lose` are ignored in every state except PLAY.
- Hold counter:
  - Loaded with `END_HOLD_FRAMES` on the cycle the state enters WIN or LOSE.
  - Decrements on `frame_start` while nonzero; saturates at 0.
  - Cleared in START and PLAY.
  - Width is `$clog2(END_HOLD_FRAMES+1)`.
- Outputs are all registered; they are decoded from the next state so they change in the same cycle as the state.
- Reset: asserting `reset` mid-game returns immediately (asynchronously) to START with debouncer, synchronizer and counters cleared.

## Timing
- Reset values:
  - state = START, `screen_sel` = 0, `level_reset` = 1, `hold_active` = 0, `leds` = 10'b00_0000_0001.
  - `sync_q`, `db_q`, `press` and all counters = 0.
- Button latency:
  - `jump_button` rises before edge 0 and stays high.
  - `sync_q` goes high at edge 2.
  - `db_q` goes high at edge 2+`DEBOUNCE_CYCLES`.
  - `press` is high for edge 3+`DEBOUNCE_CYCLES` only.
  - The state, `screen_sel` and `level_reset` change at edge 4+`DEBOUNCE_CYCLES`.
- Glitch rejection: a `sync_q` pulse shorter than `DEBOUNCE_CYCLES` cycles never changes `db_q`.
- `win`/`lose` latency: sampled high at edge N in PLAY → state = WIN/LOSE and `level_reset` = 1 at edge N+1; `hold_active` = 1 at edge N+1.
- Hold duration: `hold_active` falls at the edge after the `END_HOLD_FRAMES`th `frame_start`. A `frame_start` coinciding with the entry cycle is not counted.
- Simultaneous events: `press` coinciding with the final hold decrement is discarded, because `hold_active` is still 1 in that cycle.

## Structure
- Shared package `game_pkg`: `screen_t` enum (START, PLAY, WIN, LOSE), reused by the screen mux and renderer.
- Sub-module `button_debouncer`: 2-flop synchronizer, debounce counter and rising-edge `press` output, parameterized by `DEBOUNCE_CYCLES`. The sequencer instantiates it once.
- The top holds the state register, hold counter and output decode.

## Test plan
(All scenarios use `DEBOUNCE_CYCLES`=4, `END_HOLD_FRAMES`=3, `frame_start` every 10 cycles.)
- **Reset values:** hold `reset` → `screen_sel`=0, `level_reset`=1, `leds`=10'h001, `hold_active`=0.
- **Start press:** `jump_button` high from edge 0 and held → `press` only at edge 7, `screen_sel`=1 and `level_reset`=0 at edge 8. Holding the button for 100 cycles produces no second `press`.
- **Glitch rejection:** 3-cycle `jump_button` pulse in START → `db_q` never rises, state stays START.
- **Win/lose priority:** in PLAY, `win`=`lose`=1 at edge N → `screen_sel`=2, `hold_active`=1, `leds`[3:0]=4'b0100 at edge N+1. With `lose` alone → `screen_sel`=3.
- **Hold window:** in WIN, press during the hold (before the 3rd `frame_start`) → stays WIN. Press after `hold_active` falls → START at `press`+1 edge.
- **Mid-game reset:** `reset` asserted during PLAY → START and `level_reset`=1 immediately without waiting for a clock edge. After release, a new press is required to reach PLAY.
